// File: rtl/mem_lsu.sv
// Load/store unit sitting behind ex: one memory request per instruction,
// req/gnt/rvalid bus with byte enables, load alignment and extension,
// single-cycle register writeback, misalignment and bus-timeout pulses.
module mem_lsu #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, WB} state_t;

  state_t              state_q, state_d;
  logic [TO_CNT_W-1:0] cnt_q;
  logic                we_q;
  logic [2:0]          funct3_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          be_q;
  logic [4:0]          rd_q;
  logic [31:0]         ldata_q;
  logic                misalign_q;
  logic                bus_err_q;

  logic                legal, aligned, accept, expire;
  logic                cap_req, cap_rdata, cnt_clr, cnt_inc, mis_d, err_d;
  logic [3:0]          be_n;
  logic [31:0]         wdata_n;

  // Select the addressed lane and sign/zero-extend it according to the load type.
  function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic [31:0]        lane;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    lane = rdata >> {off, 3'b000};
    b    = lane[7:0];
    h    = lane[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, lane[7:0]};
      3'b101:  return {16'b0, lane[15:0]};
      default: return lane;
    endcase
  endfunction

  // Decode legality, alignment, byte enables and replicated store lanes of the incoming request.
  always_comb begin
    legal   = 1'b0;
    aligned = 1'b1;
    be_n    = 4'b1111;
    wdata_n = req_wdata_i;
    if (req_we_i) begin
      legal = (req_funct3_i[2] == 1'b0) && (req_funct3_i[1:0] != 2'b11);
    end else begin
      legal = (req_funct3_i[1:0] != 2'b11) && (req_funct3_i != 3'b110);
    end
    case (req_funct3_i[1:0])
      2'b01:   aligned = (req_addr_i[0] == 1'b0);
      2'b10:   aligned = (req_addr_i[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    if (req_we_i) begin
      case (req_funct3_i[1:0])
        2'b00: begin
          be_n    = 4'b0001 << req_addr_i[1:0];
          wdata_n = {4{req_wdata_i[7:0]}};
        end
        2'b01: begin
          be_n    = req_addr_i[1] ? 4'b1100 : 4'b0011;
          wdata_n = {2{req_wdata_i[15:0]}};
        end
        default: begin
          be_n    = 4'b1111;
          wdata_n = req_wdata_i;
        end
      endcase
    end
  end

  assign accept = (state_q == IDLE) && req_valid_i && legal && aligned;
  assign expire = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state logic and per-cycle control strobes of the transfer FSM.
  always_comb begin
    state_d   = state_q;
    cap_req   = 1'b0;
    cap_rdata = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    mis_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (legal && aligned) begin
            state_d = REQ;
            cap_req = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            mis_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus_gnt_i) begin
          if (we_q) begin
            state_d = IDLE;
          end else if (bus_rvalid_i) begin
            state_d   = WB;
            cap_rdata = 1'b1;
          end else begin
            state_d = RESP;
            cnt_clr = 1'b1;
          end
        end else if (expire) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP: begin
        if (bus_rvalid_i) begin
          state_d   = WB;
          cap_rdata = 1'b1;
        end else if (expire) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, timeout counter, pulses and captured request/response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rd_q       <= '0;
      ldata_q    <= '0;
    end else begin
      state_q    <= state_d;
      misalign_q <= mis_d;
      bus_err_q  <= err_d;
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + TO_CNT_W'(1);
      end
      if (cap_req) begin
        we_q     <= req_we_i;
        funct3_q <= req_funct3_i;
        addr_q   <= req_addr_i;
        wdata_q  <= wdata_n;
        be_q     <= be_n;
        rd_q     <= req_rd_i;
      end
      if (cap_rdata) begin
        ldata_q <= load_extend(funct3_q, addr_q[1:0], bus_rdata_i);
      end
    end
  end

  assign bus_req_o   = (state_q == REQ);
  assign bus_we_o    = we_q;
  assign bus_addr_o  = {addr_q[31:2], 2'b00};
  assign bus_wdata_o = wdata_q;
  assign bus_be_o    = be_q;
  assign stall_o     = accept || (state_q == REQ) || (state_q == RESP);
  assign reg_we_o    = (state_q == WB) && (rd_q != 5'd0);
  assign reg_waddr_o = rd_q;
  assign reg_wdata_o = ldata_q;
  assign misalign_o  = misalign_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed scenarios plus randomized transactions,
// each checked cycle by cycle against a transaction-level reference model.
module tb_mem_lsu;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        stall_o, reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic        misalign_o, bus_err_o;

  int checks = 0;
  int errors = 0;

  mem_lsu #(.TIMEOUT_CYCLES(TO), .TO_CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .stall_o(stall_o), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o),
    .reg_wdata_o(reg_wdata_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_legal(input bit we, input int f3);
    if (we) return f3 <= 2;
    return (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
  endfunction

  function automatic bit m_aligned(input int f3, input logic [31:0] addr);
    int bytes;
    bytes = 1 << (f3 % 4);
    if (bytes > 4) return 1;
    return (addr % bytes) == 0;
  endfunction

  function automatic logic [3:0] m_be(input bit we, input int f3, input logic [31:0] addr);
    if (!we || f3 == 2) return 4'hF;
    if (f3 == 0) return 4'(1 << (addr % 4));
    return (addr % 4 >= 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] d);
    if (f3 == 0) return (d % 256) * 32'h01010101;
    if (f3 == 1) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input int f3, input logic [31:0] addr, input logic [31:0] rdata);
    longint v, bits;
    v = rdata / (longint'(1) << (8 * (addr % 4)));
    if (f3 % 4 == 2) return 32'(v);
    bits = (f3 % 4 == 0) ? 8 : 16;
    v = v % (longint'(1) << bits);
    if (f3 < 4 && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return 32'(v);
  endfunction

  // Drive one request and act as the bus slave; gd = REQ cycles before gnt,
  // rvd = cycles from gnt to rvalid (0 = same cycle).
  task automatic do_op(input bit we, input int f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input int gd, input int rvd, input logic [31:0] rdata);
    bit ok, granted, rv_ok;
    ok = m_legal(we, f3) && m_aligned(f3, addr);
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = 3'(f3);
    req_addr_i = addr; req_wdata_i = wd; req_rd_i = rd;
    #1 chk("stall_accept", 32'(stall_o), 32'(ok));
    @(posedge clk); @(negedge clk);
    req_valid_i = 1'b0;
    req_addr_i = $urandom; req_wdata_i = $urandom;
    #1;
    if (!ok) begin
      chk("misalign_pulse", 32'(misalign_o), 1);
      chk("misalign_noreq", 32'(bus_req_o), 0);
      chk("misalign_stall", 32'(stall_o), 0);
      @(negedge clk); #1;
      chk("misalign_clear", 32'(misalign_o), 0);
      chk("misalign_idle", 32'(bus_req_o), 0);
      return;
    end
    granted = 0;
    for (int k = 0; k < TO; k++) begin
      chk("req_high", 32'(bus_req_o), 1);
      chk("req_stall", 32'(stall_o), 1);
      chk("req_we", 32'(bus_we_o), 32'(we));
      chk("req_addr", bus_addr_o, addr - (addr % 4));
      chk("req_be", 32'(bus_be_o), 32'(m_be(we, f3, addr)));
      if (we) chk("req_wdata", bus_wdata_o, m_wdata(f3, wd));
      if (k == gd) begin
        bus_gnt_i = 1'b1;
        granted = 1;
        if (!we && rvd == 0) begin bus_rvalid_i = 1'b1; bus_rdata_i = rdata; end
      end
      @(posedge clk); @(negedge clk);
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = $urandom;
      #1;
      if (granted) break;
    end
    if (!granted) begin
      chk("timeout_err", 32'(bus_err_o), 1);
      chk("timeout_noreq", 32'(bus_req_o), 0);
      chk("timeout_nowb", 32'(reg_we_o), 0);
      chk("timeout_stall", 32'(stall_o), 0);
      @(negedge clk); #1;
      chk("timeout_clear", 32'(bus_err_o), 0);
      return;
    end
    chk("no_err", 32'(bus_err_o), 0);
    if (we) begin
      chk("store_done_req", 32'(bus_req_o), 0);
      chk("store_nowb", 32'(reg_we_o), 0);
      chk("store_stall", 32'(stall_o), 0);
      return;
    end
    if (rvd > 0) begin
      rv_ok = 0;
      for (int m = 0; m < TO; m++) begin
        chk("resp_noreq", 32'(bus_req_o), 0);
        chk("resp_stall", 32'(stall_o), 1);
        chk("resp_nowb", 32'(reg_we_o), 0);
        if (m == rvd - 1) begin bus_rvalid_i = 1'b1; bus_rdata_i = rdata; rv_ok = 1; end
        @(posedge clk); @(negedge clk);
        bus_rvalid_i = 1'b0; bus_rdata_i = $urandom;
        #1;
        if (rv_ok) break;
      end
      if (!rv_ok) begin
        chk("resp_timeout_err", 32'(bus_err_o), 1);
        chk("resp_timeout_nowb", 32'(reg_we_o), 0);
        chk("resp_timeout_stall", 32'(stall_o), 0);
        @(negedge clk); #1;
        chk("resp_timeout_clear", 32'(bus_err_o), 0);
        return;
      end
    end
    chk("wb_we", 32'(reg_we_o), 32'(rd != 0));
    chk("wb_waddr", 32'(reg_waddr_o), 32'(rd));
    chk("wb_wdata", reg_wdata_o, m_load(f3, addr, rdata));
    chk("wb_stall", 32'(stall_o), 0);
    chk("wb_noreq", 32'(bus_req_o), 0);
    @(negedge clk); #1;
    chk("wb_once", 32'(reg_we_o), 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid_i = 0; req_we_i = 0; req_funct3_i = 0; req_addr_i = 0;
    req_wdata_i = 0; req_rd_i = 0;
    bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_req", 32'(bus_req_o), 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_be", 32'(bus_be_o), 0);
    chk("rst_regwe", 32'(reg_we_o), 0);
    chk("rst_wdata", reg_wdata_o, 0);
    chk("rst_stall", 32'(stall_o), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed scenarios
    do_op(0, 2, 32'h100, 0, 5'd5, 0, 2, 32'hDEADBEEF);
    do_op(0, 0, 32'h203, 0, 5'd6, 0, 1, 32'h80FF0000);
    do_op(0, 4, 32'h203, 0, 5'd7, 1, 0, 32'h80FF0000);
    do_op(0, 5, 32'h202, 0, 5'd8, 0, 3, 32'h80FF0000);
    do_op(1, 0, 32'h11, 32'hAB, 5'd0, 0, 0, 0);
    do_op(1, 1, 32'h12, 32'h1234, 5'd0, 2, 0, 0);
    do_op(0, 1, 32'h3, 0, 5'd1, 0, 0, 0);
    do_op(1, 4, 32'h40, 0, 5'd1, 0, 0, 0);
    do_op(0, 2, 32'h300, 0, 5'd9, TO, 0, 0);
    do_op(0, 2, 32'h304, 0, 5'd9, TO - 1, 1, 32'h01234567);
    do_op(0, 2, 32'h308, 0, 5'd10, 0, TO + 1, 0);
    do_op(0, 2, 32'h30C, 0, 5'd10, 0, TO, 32'h76543210);
    do_op(0, 0, 32'h401, 0, 5'd0, 0, 1, 32'h00008000);

    // Reset while waiting for read data
    req_valid_i = 1; req_we_i = 0; req_funct3_i = 3'b010; req_addr_i = 32'h500; req_rd_i = 5'd3;
    @(posedge clk); @(negedge clk);
    req_valid_i = 0;
    bus_gnt_i = 1;
    @(posedge clk); @(negedge clk);
    bus_gnt_i = 0;
    #1 chk("rstresp_stall", 32'(stall_o), 1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstresp_req", 32'(bus_req_o), 0);
    chk("rstresp_addr", bus_addr_o, 0);
    chk("rstresp_waddr", 32'(reg_waddr_o), 0);
    chk("rstresp_stall0", 32'(stall_o), 0);
    chk("rstresp_err", 32'(bus_err_o), 0);
    bus_rvalid_i = 1; bus_rdata_i = 32'hFFFFFFFF;
    @(posedge clk); @(negedge clk);
    bus_rvalid_i = 0;
    #1;
    chk("rstresp_ignore_we", 32'(reg_we_o), 0);
    chk("rstresp_ignore_stall", 32'(stall_o), 0);
    @(negedge clk); #1;
    chk("rstresp_ignore_we2", 32'(reg_we_o), 0);
    do_op(0, 2, 32'h504, 0, 5'd4, 0, 1, 32'hCAFEF00D);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      bit we;
      int f3, gd, rvd;
      logic [31:0] a;
      we  = $urandom_range(0, 1);
      f3  = $urandom_range(0, 7);
      a   = $urandom;
      if ($urandom_range(0, 2) != 0) a = a - (a % 4) + ((f3 % 4 == 1) ? 2 * $urandom_range(0, 1) : 0);
      gd  = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 1) : $urandom_range(0, 2);
      rvd = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 3);
      do_op(we, f3, a, $urandom, 5'($urandom_range(0, 31)), gd, rvd, $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
